adder_result_buffer: RTL and testbench

Downstream sink for the 64-bit pipelined adder. Captures every 65-bit sum the adder qualifies with `o_en` into an 8-entry FIFO and presents it on a valid/ready interface. The adder has no backpressure, so the block also tracks sums in flight and gives the issuing logic an `issue_ok` credit. It sits between `adder_pipe_64bit` and the result consumer.

---
 rtl/adder_pipe_pkg.sv | 8 +
 rtl/result_fifo_mem.sv | 21 ++
 rtl/adder_result_buffer.sv | 79 +++++++
 tb/tb_adder_result_buffer.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/adder_pipe_pkg.sv
// Shared constants and types for the 64-bit adder pipeline and its result sink.
package adder_pipe_pkg;
    localparam int DATA_WIDTH     = 64;
    localparam int RESULT_W       = DATA_WIDTH + 1;
    localparam int RES_FIFO_DEPTH = 8;

    typedef logic [RESULT_W-1:0] result_t;
endpackage

// File: rtl/result_fifo_mem.sv
// Result FIFO storage: one write port, one asynchronous read port, no reset.
module result_fifo_mem #(
    parameter int DEPTH = 8,
    parameter int W     = 65,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [PTR_W-1:0] wr_addr,
    input  logic [W-1:0]     wr_data,
    input  logic [PTR_W-1:0] rd_addr,
    output logic [W-1:0]     rd_data
);
    logic [DEPTH-1:0][W-1:0] mem;

    always_ff @(posedge clk) begin
        if (we) mem[wr_addr] <= wr_data;
    end

    assign rd_data = mem[rd_addr];
endmodule

// File: rtl/adder_result_buffer.sv
// Result sink for the pipelined adder: 8-deep FIFO with valid/ready output,
// in-flight tracking and an issue credit for the non-backpressurable adder.
module adder_result_buffer #(
    parameter int DATA_WIDTH = adder_pipe_pkg::DATA_WIDTH,
    parameter int DEPTH      = adder_pipe_pkg::RES_FIFO_DEPTH,
    parameter int CNT_W      = $clog2(DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  issue,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH:0]   in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH:0]   out_data,
    output logic                  issue_ok,
    output logic [CNT_W-1:0]      count,
    output logic                  ovf,
    output logic                  err_inflight,
    input  logic                  clr_err
);
    localparam int               PTR_W    = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] FULL     = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] INFL_MAX = '1;

    logic [PTR_W-1:0]  wr_ptr, rd_ptr;
    logic [CNT_W-1:0]  inflight;
    logic [DATA_WIDTH:0] rd_data;
    logic              push, pop, full, ovf_set, err_set;

    assign full      = (count == FULL);
    assign out_valid = (count != '0);
    assign pop       = out_valid && out_ready;
    // A full FIFO still accepts a write when the head leaves in the same cycle.
    assign push      = in_valid && (!full || pop);
    assign ovf_set   = in_valid && !push;
    assign err_set   = (in_valid && inflight == '0) || (issue && inflight == INFL_MAX);
    assign issue_ok  = ({1'b0, count} + {1'b0, inflight}) < (CNT_W+1)'(DEPTH);
    assign out_data  = out_valid ? rd_data : '0;

    result_fifo_mem #(
        .DEPTH (DEPTH),
        .W     (DATA_WIDTH + 1),
        .PTR_W (PTR_W)
    ) u_mem (
        .clk     (clk),
        .we      (push),
        .wr_addr (wr_ptr),
        .wr_data (in_data),
        .rd_addr (rd_ptr),
        .rd_data (rd_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            inflight     <= '0;
            ovf          <= 1'b0;
            err_inflight <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            // Saturating at both ends; the limit hit is reported via err_set.
            if (issue && !in_valid && inflight != INFL_MAX)
                inflight <= inflight + 1'b1;
            else if (in_valid && !issue && inflight != '0)
                inflight <= inflight - 1'b1;
            ovf          <= ovf_set | (ovf & ~clr_err);
            err_inflight <= err_set | (err_inflight & ~clr_err);
        end
    end
endmodule

// File: tb/tb_adder_result_buffer.sv
// Directed self-checking bench for adder_result_buffer.
module tb_adder_result_buffer;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        issue, in_valid, out_ready, clr_err;
    logic [64:0] in_data;
    logic        out_valid, issue_ok, ovf, err_inflight;
    logic [64:0] out_data;
    logic [3:0]  count;

    int errs   = 0;
    int checks = 0;

    adder_result_buffer dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .issue        (issue),
        .in_valid     (in_valid),
        .in_data      (in_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .issue_ok     (issue_ok),
        .count        (count),
        .ovf          (ovf),
        .err_inflight (err_inflight),
        .clr_err      (clr_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [64:0] act, input logic [64:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        issue = 0; in_valid = 0; out_ready = 0; clr_err = 0; in_data = '0;
    endtask

    initial begin
        logic [3:0] pipe;
        logic [3:0] pat;
        int n_iss, n_in, sent, rcvd;

        idle();
        rst_n = 1'b0;
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_count", count, 0);
        chk("rst_issue_ok", issue_ok, 1);
        chk("rst_ovf", ovf, 0);
        chk("rst_err", err_inflight, 0);
        #20 rst_n = 1'b1;
        step();

        // single pass: issue, result 4 cycles later
        issue = 1; step(); issue = 0;
        chk("sp_inflight1", dut.inflight, 1);
        step(); step(); step();
        in_valid = 1; in_data = 65'h1_0000_0000_0000_0001;
        chk("sp_not_bypass", out_valid, 0);
        step(); idle();
        chk("sp_out_valid", out_valid, 1);
        chk("sp_out_data", out_data, 65'h1_0000_0000_0000_0001);
        chk("sp_inflight0", dut.inflight, 0);
        chk("sp_err", err_inflight, 0);
        out_ready = 1; step(); idle();
        chk("sp_drained", count, 0);
        chk("sp_masked", out_data, 0);

        // credit fill with a 4-cycle adder model, no consumer
        pipe = '0; n_iss = 0; n_in = 0;
        for (int c = 0; c < 20; c++) begin
            issue    = issue_ok;
            in_valid = pipe[3];
            in_data  = 65'(100 + n_in);
            if (issue) n_iss++;
            if (in_valid) n_in++;
            step();
            pipe = {pipe[2:0], issue};
        end
        idle();
        chk("cf_issues", 65'(n_iss), 8);
        chk("cf_count", count, 8);
        chk("cf_issue_ok", issue_ok, 0);
        chk("cf_ovf", ovf, 0);
        chk("cf_err", err_inflight, 0);
        chk("cf_head", out_data, 100);

        // full boundary: dropped write, then simultaneous push/pop
        in_valid = 1; in_data = 65'h1DEAD; step(); idle();
        chk("fb_ovf", ovf, 1);
        chk("fb_count", count, 8);
        chk("fb_head", out_data, 100);
        clr_err = 1; step(); idle();
        chk("fb_clr_ovf", ovf, 0);
        chk("fb_clr_err", err_inflight, 0);
        in_valid = 1; in_data = 65'd200; out_ready = 1; step(); idle();
        chk("fb_pp_count", count, 8);
        chk("fb_pp_ovf", ovf, 0);
        chk("fb_pp_head", out_data, 101);
        for (int i = 0; i < 8; i++) begin
            out_ready = 1;
            chk("fb_drain", out_data, (i == 7) ? 65'd200 : 65'(101 + i));
            step();
        end
        idle();
        chk("fb_empty", out_valid, 0);
        clr_err = 1; step(); idle();

        // streaming 0..19 with out_ready pattern 1,0,1,1
        pat = 4'b1101; sent = 0; rcvd = 0;
        for (int c = 0; c < 200 && rcvd < 20; c++) begin
            in_valid  = (sent < 20);
            in_data   = 65'(sent);
            out_ready = pat[c % 4];
            if (out_valid && out_ready) begin
                chk("st_order", out_data, 65'(rcvd));
                rcvd++;
            end
            step();
            if (in_valid) sent++;
        end
        idle();
        chk("st_received", 65'(rcvd), 20);
        chk("st_ovf", ovf, 0);
        chk("st_empty", count, 0);
        clr_err = 1; step(); idle();
        chk("st_err_clr", err_inflight, 0);

        // stray results and clear priority
        in_valid = 1; in_data = 65'd7; step(); idle();
        chk("sr_err_set", err_inflight, 1);
        chk("sr_pushed", count, 1);
        clr_err = 1; step(); idle();
        chk("sr_err_clr", err_inflight, 0);
        clr_err = 1; in_valid = 1; in_data = 65'd8; step(); idle();
        chk("sr_set_wins", err_inflight, 1);
        out_ready = 1; step(); step(); idle();
        clr_err = 1; step(); idle();
        chk("sr_drained", count, 0);

        // reset mid-stream with count=5, inflight=3
        for (int i = 0; i < 5; i++) begin
            in_valid = 1; in_data = 65'(i); step();
        end
        idle();
        for (int i = 0; i < 3; i++) begin
            issue = 1; step();
        end
        idle();
        chk("rm_count5", count, 5);
        chk("rm_inflight3", dut.inflight, 3);
        chk("rm_issue_ok0", issue_ok, 0);
        #2 rst_n = 1'b0;
        #1;
        chk("rm_count0", count, 0);
        chk("rm_out_valid", out_valid, 0);
        chk("rm_out_data", out_data, 0);
        #3 rst_n = 1'b1;
        step();
        chk("rm_issue_ok1", issue_ok, 1);
        chk("rm_inflight0", dut.inflight, 0);
        chk("rm_err0", err_inflight, 0);
        in_valid = 1; in_data = 65'h55; step(); idle();
        chk("rm_late_err", err_inflight, 1);
        chk("rm_late_push", out_data, 65'h55);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
